i2c_write_master: RTL and testbench

- Single-master I2C write controller that sequences one complete register-write transaction on the bus.
- Transaction order: START, 7-bit device address + W, register address byte, one data byte, STOP.
- Takes a one-cycle command from the host side and drives open-drain SCL/SDA toward the slave-side receiver.
- Samples the slave's ACK bit after each byte and reports completion or NACK.

---
 rtl/i2c_write_master.sv | 200 ++++++++++++++++++++
 tb/tb_i2c_write_master.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_write_master.sv
// Single-master I2C register-write controller: START, addr+W, reg byte, data byte, STOP.
// Drives open-drain SCL/SDA from registered outputs and reports ACK/NACK outcome.
module i2c_write_master #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned DIV_W   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic [6:0] dev_addr_i,
  input  logic [7:0] reg_addr_i,
  input  logic [7:0] wdata_i,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_oe_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       nack_o
);

  localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK, S_DATA, S_DATA_ACK, S_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [1:0]       qtr_q, qtr_d;
  logic [2:0]       bit_q, bit_d;
  logic [6:0]       dev_q, dev_d;
  logic [7:0]       reg_q, reg_d;
  logic [7:0]       data_q, data_d;
  logic             scl_q, scl_d;
  logic             sda_oe_q, sda_oe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             nack_q, nack_d;

  logic             tick;
  logic [7:0]       byte_sel;
  logic             cur_bit;
  logic             scl_pulse;

  // Next-state, counters and registered pin levels derived from the next phase
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    qtr_d    = qtr_q;
    bit_d    = bit_q;
    dev_d    = dev_q;
    reg_d    = reg_q;
    data_d   = data_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    nack_d   = nack_q;
    scl_d    = 1'b1;
    sda_oe_d = 1'b0;
    byte_sel = 8'h00;
    cur_bit  = 1'b0;
    scl_pulse = 1'b0;

    tick = busy_q && (cnt_q == CNT_LAST);
    if (busy_q) cnt_d = tick ? '0 : cnt_q + DIV_W'(1);

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_START;
          cnt_d   = '0;
          qtr_d   = 2'd0;
          bit_d   = 3'd0;
          dev_d   = dev_addr_i;
          reg_d   = reg_addr_i;
          data_d  = wdata_i;
          busy_d  = 1'b1;
          nack_d  = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          if (qtr_q == 2'd1) begin
            state_d = S_ADDR;
            qtr_d   = 2'd0;
            bit_d   = 3'd0;
          end else begin
            qtr_d = qtr_q + 2'd1;
          end
        end
      end
      S_ADDR, S_REG, S_DATA: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd3) begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_d = (state_q == S_ADDR) ? S_ADDR_ACK :
                        (state_q == S_REG)  ? S_REG_ACK  : S_DATA_ACK;
            end
          end
        end
      end
      S_ADDR_ACK, S_REG_ACK, S_DATA_ACK: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          // ACK is sampled mid-way through SCL high
          if (qtr_q == 2'd1 && sda_i) nack_d = 1'b1;
          if (qtr_q == 2'd3) begin
            bit_d = 3'd0;
            if (nack_q || state_q == S_DATA_ACK) state_d = S_STOP;
            else if (state_q == S_ADDR_ACK)      state_d = S_REG;
            else                                 state_d = S_DATA;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (qtr_q == 2'd2) begin
            state_d = S_IDLE;
            qtr_d   = 2'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            qtr_d = qtr_q + 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_ADDR:  byte_sel = {dev_d, 1'b0};
      S_REG:   byte_sel = reg_d;
      S_DATA:  byte_sel = data_d;
      default: byte_sel = 8'h00;
    endcase
    cur_bit   = byte_sel[3'd7 - bit_d];
    scl_pulse = (qtr_d == 2'd1) || (qtr_d == 2'd2);

    case (state_d)
      S_START: begin
        scl_d    = 1'b1;
        sda_oe_d = (qtr_d == 2'd1);
      end
      S_ADDR, S_REG, S_DATA: begin
        scl_d    = scl_pulse;
        sda_oe_d = ~cur_bit;
      end
      S_ADDR_ACK, S_REG_ACK, S_DATA_ACK: begin
        scl_d    = scl_pulse;
        sda_oe_d = 1'b0;
      end
      S_STOP: begin
        scl_d    = (qtr_d != 2'd0);
        sda_oe_d = (qtr_d != 2'd2);
      end
      default: begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      qtr_q    <= 2'd0;
      bit_q    <= 3'd0;
      dev_q    <= 7'd0;
      reg_q    <= 8'd0;
      data_q   <= 8'd0;
      scl_q    <= 1'b1;
      sda_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      nack_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      qtr_q    <= qtr_d;
      bit_q    <= bit_d;
      dev_q    <= dev_d;
      reg_q    <= reg_d;
      data_q   <= data_d;
      scl_q    <= scl_d;
      sda_oe_q <= sda_oe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      nack_q   <= nack_d;
    end
  end

  assign scl_o    = scl_q;
  assign sda_oe_o = sda_oe_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign nack_o   = nack_q;

endmodule

// File: tb/tb_i2c_write_master.sv
// Bench for i2c_write_master: bus monitor + ACK-configurable slave, byte scoreboard,
// table of write commands plus hand sequences for ignored start, mid-byte reset and CLK_DIV=1.
module tb_i2c_write_master;

  logic       clk;
  logic       reset;
  logic       start;
  logic [6:0] dev;
  logic [7:0] ra;
  logic [7:0] wd;
  wire        sda_i;
  logic       scl, oe, busy, done, nack;

  logic       start1;
  logic       sda1_i;
  logic       scl1, oe1, busy1, done1, nack1;

  logic       pull;
  logic [2:0] ack_mask;

  int checks;
  int errors;
  int cyc;

  logic [7:0] exp_q[$];
  logic [7:0] got[$];
  int gbase;
  int start_cnt, stop_cnt, rise_cnt, done_cnt, ack_bad;
  int s0, p0, r0, d0, a0;
  int acc_cyc;

  typedef struct {
    logic [6:0] dev;
    logic [7:0] ra;
    logic [7:0] wd;
    logic [2:0] mask;
    int         lat;
    logic       nack;
  } vec_t;
  vec_t tbl[6];

  assign sda_i = ~(oe | pull);

  i2c_write_master #(.CLK_DIV(4), .DIV_W(16)) u_dut (
    .clk(clk), .reset(reset), .start_i(start), .dev_addr_i(dev), .reg_addr_i(ra),
    .wdata_i(wd), .sda_i(sda_i), .scl_o(scl), .sda_oe_o(oe), .busy_o(busy),
    .done_o(done), .nack_o(nack)
  );

  i2c_write_master #(.CLK_DIV(1), .DIV_W(16)) u_dut1 (
    .clk(clk), .reset(reset), .start_i(start1), .dev_addr_i(7'h4B), .reg_addr_i(8'hAB),
    .wdata_i(8'h5A), .sda_i(sda1_i), .scl_o(scl1), .sda_oe_o(oe1), .busy_o(busy1),
    .done_o(done1), .nack_o(nack1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Bus monitor and slave: captures bytes on SCL rise, pulls SDA low in configured ACK slots
  logic       prev_scl, prev_oe;
  int         bitcnt, byteidx;
  logic [7:0] sh;
  always @(negedge clk) begin
    if (!reset) begin
      pull = 1'b0; bitcnt = 0; byteidx = 0; prev_scl = 1'b1; prev_oe = 1'b0;
    end else begin
      if (done) done_cnt = done_cnt + 1;
      if (prev_scl && scl) begin
        if (!prev_oe && oe) begin start_cnt = start_cnt + 1; bitcnt = 0; byteidx = 0; end
        if (prev_oe && !oe) begin stop_cnt = stop_cnt + 1; bitcnt = 0; end
      end
      if (!prev_scl && scl) begin
        rise_cnt = rise_cnt + 1;
        if (bitcnt < 8) begin
          sh = {sh[6:0], ~(oe | pull)};
          bitcnt = bitcnt + 1;
          if (bitcnt == 8) got.push_back(sh);
        end else begin
          if (oe) ack_bad = ack_bad + 1;
          bitcnt = 0;
          byteidx = byteidx + 1;
        end
      end
      if (prev_scl && !scl) pull = (bitcnt == 8) && (byteidx < 3) && ack_mask[byteidx];
      prev_scl = scl;
      prev_oe  = oe;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks = checks + 1;
    if (act !== expv) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic send(input logic [6:0] d, input logic [7:0] r, input logic [7:0] w,
                      input logic [2:0] m);
    @(posedge clk); #1;
    dev = d; ra = r; wd = w; ack_mask = m; start = 1'b1;
    exp_q.delete();
    exp_q.push_back({d, 1'b0});
    if (m[0]) exp_q.push_back(r);
    if (m[0] && m[1]) exp_q.push_back(w);
    gbase = got.size();
    s0 = start_cnt; p0 = stop_cnt; r0 = rise_cnt; d0 = done_cnt; a0 = ack_bad;
    @(posedge clk); #1;
    acc_cyc = cyc;
    start = 1'b0;
    dev = 7'h00; ra = 8'hFF; wd = 8'hC3;
    chk("busy_after_accept", busy, 1);
    chk("nack_cleared_on_accept", nack, 0);
  endtask

  task automatic finish_txn(input int exp_lat, input logic exp_nack);
    int lat;
    int n;
    lat = -1;
    for (int k = 0; k < 1000; k++) begin
      if (done) begin lat = cyc - acc_cyc; break; end
      @(posedge clk); #1;
    end
    if (lat < 0) begin
      checks = checks + 1; errors = errors + 1;
      $display("FAIL done_timeout: no done_o within 1000 cycles");
    end else begin
      chk("latency", lat, exp_lat);
      chk("nack", nack, exp_nack);
      chk("busy_at_done", busy, 0);
      @(posedge clk); #1;
      chk("done_one_cycle", done, 0);
    end
    repeat (4) @(posedge clk);
    #1;
    n = got.size() - gbase;
    chk("byte_count", n, exp_q.size());
    while (exp_q.size() > 0 && gbase < got.size()) begin
      chk("bus_byte", got[gbase], exp_q.pop_front());
      gbase = gbase + 1;
    end
    chk("start_cond", start_cnt - s0, 1);
    chk("stop_cond", stop_cnt - p0, 1);
    chk("scl_rises", rise_cnt - r0, 9 * n + 1);
    chk("done_pulses", done_cnt - d0, 1);
    chk("ack_slot_released", ack_bad - a0, 0);
  endtask

  initial begin
    int lat1, last_rise, bad_per, hi_chg, rises;
    logic p_scl, p_oe;
    checks = 0; errors = 0; cyc = 0;
    start_cnt = 0; stop_cnt = 0; rise_cnt = 0; done_cnt = 0; ack_bad = 0;
    tbl[0] = '{7'h4B, 8'hAB, 8'h5A, 3'b111, 452, 1'b0};
    tbl[1] = '{7'h4B, 8'hAB, 8'h5A, 3'b000, 164, 1'b1};
    tbl[2] = '{7'h4B, 8'hAB, 8'h5A, 3'b001, 308, 1'b1};
    tbl[3] = '{7'h12, 8'h34, 8'h56, 3'b111, 452, 1'b0};
    tbl[4] = '{7'h7F, 8'hFF, 8'h00, 3'b011, 452, 1'b1};
    tbl[5] = '{7'h00, 8'h00, 8'hFF, 3'b111, 452, 1'b0};

    reset = 1'b0; start = 1'b0; start1 = 1'b0; sda1_i = 1'b0;
    dev = '0; ra = '0; wd = '0; ack_mask = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_scl", scl, 1);
    chk("rst_sda_oe", oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_nack", nack, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    foreach (tbl[i]) begin
      send(tbl[i].dev, tbl[i].ra, tbl[i].wd, tbl[i].mask);
      finish_txn(tbl[i].lat, tbl[i].nack);
    end

    // start_i while busy is ignored
    send(7'h4B, 8'hAB, 8'h5A, 3'b111);
    repeat (99) @(posedge clk);
    #1;
    dev = 7'h11; ra = 8'h22; wd = 8'h33; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    finish_txn(452, 1'b0);

    // asynchronous reset in the middle of the register byte
    send(7'h4B, 8'hAB, 8'h5A, 3'b111);
    repeat (200) @(posedge clk);
    #1;
    chk("pre_reset_busy", busy, 1);
    reset = 1'b0;
    #1;
    chk("abort_scl", scl, 1);
    chk("abort_sda_oe", oe, 0);
    chk("abort_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    send(7'h2C, 8'h01, 8'h80, 3'b111);
    finish_txn(452, 1'b0);

    // CLK_DIV=1 instance: timing and SDA stability
    @(posedge clk); #1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    acc_cyc = cyc;
    lat1 = -1; last_rise = -1; bad_per = 0; hi_chg = 0; rises = 0;
    p_scl = scl1; p_oe = oe1;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (!p_scl && scl1) begin
        if (last_rise >= 0 && (cyc - last_rise) != 4) bad_per = bad_per + 1;
        last_rise = cyc;
        rises = rises + 1;
      end
      if (p_scl && scl1 && (p_oe != oe1)) hi_chg = hi_chg + 1;
      p_scl = scl1; p_oe = oe1;
      if (done1) begin lat1 = cyc - acc_cyc; break; end
    end
    chk("div1_latency", lat1, 113);
    chk("div1_scl_period", bad_per, 0);
    chk("div1_sda_changes_scl_high", hi_chg, 2);
    chk("div1_scl_rises", rises, 28);
    chk("div1_nack", nack1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
